// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the decode-side forwarding / hazard unit:
// forwarding select encodings, register index width and the in-flight slot.
package fwd_hazard_unit_pkg;

  // Register index width used by every file of this block
  localparam int REG_AW = 5;

  // Width of the HI/LO busy counter (MDU_LATENCY range 1..15)
  localparam int MDU_CW = 4;

  // Operand source selected by the EX-stage forwarding mux
  typedef enum logic [1:0] {
    FW_RF    = 2'd0,  // register file value
    FW_MEM   = 2'd1,  // ALU result now in MEM
    FW_WB    = 2'd2,  // value now in WB
    FW_MEMRD = 2'd3   // read data produced this cycle in MEM
  } fw_sel_e;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } slot_t;

  // A slot produces register r; register 0 is never a producer
  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.dest != {REG_AW{1'b0}}) && (s.dest == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage bundle between the ID stage and the forwarding/hazard unit.
// master = ID stage side, slave = fwd_hazard_unit.
interface fwd_hazard_unit_if;
  import fwd_hazard_unit_pkg::*;

  logic              ID_Valid;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              ID_UsesRs;
  logic              ID_UsesRt;
  logic [REG_AW-1:0] ID_RegDest;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_IsMulDiv;
  logic              ID_ReadsHiLo;
  logic              Flush;
  logic              Stall;
  logic [1:0]        FWMuxAControl;
  logic [1:0]        FWMuxBControl;
  logic              MDUBusy;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegDest,
    output ID_RegWrite, ID_MemRead, ID_IsMulDiv, ID_ReadsHiLo, Flush,
    input  Stall, FWMuxAControl, FWMuxBControl, MDUBusy
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegDest,
    input  ID_RegWrite, ID_MemRead, ID_IsMulDiv, ID_ReadsHiLo, Flush,
    output Stall, FWMuxAControl, FWMuxBControl, MDUBusy
  );

endinterface

// File: rtl/fwd_hazard_unit_select.sv
// Forwarding select for one source operand: compares the source index with
// the EX and MEM in-flight slots; the younger (EX) producer wins.
module fwd_select
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  slot_t             ex_slot,
  input  slot_t             mem_slot,
  output fw_sel_e           sel
);

  // A load already in MEM delivers through the WB path, so its memread
  // flag does not alter the select.
  logic mem_memread_unused_s;
  assign mem_memread_unused_s = mem_slot.memread;

  // Priority comparator: EX match first, then MEM, else register file
  always_comb begin
    sel = FW_RF;
    if (!use_src) begin
      sel = FW_RF;
    end else if (slot_match(ex_slot, src)) begin
      if (ex_slot.memread) begin
        sel = FW_MEMRD;
      end else begin
        sel = FW_MEM;
      end
    end else if (slot_match(mem_slot, src)) begin
      sel = FW_WB;
    end else begin
      sel = FW_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-side forwarding and hazard unit.
// Tracks destinations of instructions in EX and MEM, registers the EX
// forwarding selects, and raises the ID stall for load-use and HI/LO hazards.
// Build option: FWD_MEMREAD_EN -- when defined, a load result is forwarded
// straight from MEM read data (select 3) and load-use never stalls.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  fwd_hazard_unit_if.slave bus
);

  localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_LATENCY);

  slot_t             ex_r;
  slot_t             mem_r;
  fw_sel_e           fwa_r;
  fw_sel_e           fwb_r;
  logic [MDU_CW-1:0] mdu_cnt_r;

  slot_t   id_slot_s;
  fw_sel_e sel_a_s;
  fw_sel_e sel_b_s;
  logic    mdu_busy_s;
  logic    load_use_s;
  logic    hilo_hazard_s;
  logic    stall_s;
  logic    advance_s;

  fwd_select u_sel_a (
    .src      (bus.ID_Rs),
    .use_src  (bus.ID_UsesRs),
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .sel      (sel_a_s)
  );

  fwd_select u_sel_b (
    .src      (bus.ID_Rt),
    .use_src  (bus.ID_UsesRt),
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .sel      (sel_b_s)
  );

  // Hazard detection, stall and advance decision for the ID instruction
  always_comb begin
    mdu_busy_s    = 1'b0;
    load_use_s    = 1'b0;
    hilo_hazard_s = 1'b0;
    stall_s       = 1'b0;
    advance_s     = 1'b0;
    id_slot_s     = '{valid: 1'b1, dest: bus.ID_RegDest,
                      regwrite: bus.ID_RegWrite, memread: bus.ID_MemRead};

    mdu_busy_s = (mdu_cnt_r != {MDU_CW{1'b0}});
`ifdef FWD_MEMREAD_EN
    load_use_s = 1'b0;
`else
    // Select 3 means the producer is a load still in EX: data is not ready
    load_use_s = (sel_a_s == FW_MEMRD) || (sel_b_s == FW_MEMRD);
`endif
    hilo_hazard_s = mdu_busy_s && (bus.ID_ReadsHiLo || bus.ID_IsMulDiv);

    // Flush kills the ID instruction, so it can never be held
    if (bus.ID_Valid && !bus.Flush) begin
      stall_s = load_use_s || hilo_hazard_s;
    end else begin
      stall_s = 1'b0;
    end
    advance_s = bus.ID_Valid && !stall_s && !bus.Flush;
  end

  // In-flight slots: MEM follows EX; EX takes the ID instruction or a bubble
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ex_r  <= '{valid: 1'b0, dest: {REG_AW{1'b0}}, regwrite: 1'b0, memread: 1'b0};
      mem_r <= '{valid: 1'b0, dest: {REG_AW{1'b0}}, regwrite: 1'b0, memread: 1'b0};
    end else begin
      mem_r <= ex_r;
      if (advance_s) begin
        ex_r <= id_slot_s;
      end else begin
        ex_r <= '{valid: 1'b0, dest: {REG_AW{1'b0}}, regwrite: 1'b0, memread: 1'b0};
      end
    end
  end

  // Forwarding selects travel with the instruction into EX; bubbles get RF
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fwa_r <= FW_RF;
      fwb_r <= FW_RF;
    end else if (advance_s) begin
      fwa_r <= sel_a_s;
      fwb_r <= sel_b_s;
    end else begin
      fwa_r <= FW_RF;
      fwb_r <= FW_RF;
    end
  end

  // HI/LO availability countdown, restarted by each issued mult/div
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mdu_cnt_r <= {MDU_CW{1'b0}};
    end else if (advance_s && bus.ID_IsMulDiv) begin
      mdu_cnt_r <= MDU_LOAD;
    end else if (mdu_cnt_r != {MDU_CW{1'b0}}) begin
      mdu_cnt_r <= mdu_cnt_r - {{(MDU_CW-1){1'b0}}, 1'b1};
    end else begin
      mdu_cnt_r <= {MDU_CW{1'b0}};
    end
  end

  assign bus.Stall         = stall_s;
  assign bus.MDUBusy       = mdu_busy_s;
  assign bus.FWMuxAControl = fwa_r;
  assign bus.FWMuxBControl = fwb_r;

endmodule
